// File: rtl/romc_mp.sv
// Multi-port constant ROM with per-port elastic read pipelines
// and a background signature scan (modular sum of all words).
module romc_mp #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int NPORTS  = 2,
  parameter int LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        req_vld,
  input  logic [NPORTS*ADDR_W-1:0] req_addr,
  output logic [NPORTS-1:0]        req_rdy,
  output logic [NPORTS-1:0]        rsp_vld,
  output logic [NPORTS*DATA_W-1:0] rsp_data,
  output logic [NPORTS-1:0]        rsp_err,
  input  logic [NPORTS-1:0]        rsp_rdy,
  input  logic                     scan_start,
  output logic                     scan_busy,
  output logic                     scan_done,
  output logic [DATA_W-1:0]        scan_sig
);

  localparam int NB = DATA_W / 8;

  function automatic logic [DATA_W-1:0] rom_word(
    input logic [ADDR_W-1:0] a
  );
    logic [7:0] b;
    b = 8'(a) * 8'd17;
    return {NB{b}};
  endfunction

  function automatic logic oor(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= (ADDR_W+1)'(DEPTH);
  endfunction

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] err_q, err_d;
    logic [DATA_W-1:0]  dat_q [LATENCY];
    logic [DATA_W-1:0]  dat_d [LATENCY];
    logic [ADDR_W-1:0]  a;
    logic               adv;

    assign a   = req_addr[p*ADDR_W +: ADDR_W];
    // whole pipe moves together; stalls only when the tail is blocked
    assign adv = !vld_q[LATENCY-1] || rsp_rdy[p];

    always_comb begin
      vld_d = vld_q;
      err_d = err_q;
      dat_d = dat_q;
      if (adv) begin
        vld_d[0] = req_vld[p];
        if (req_vld[p]) begin
          err_d[0] = oor(a);
          dat_d[0] = oor(a) ? '0 : rom_word(a);
        end
        for (int s = 1; s < LATENCY; s++) begin
          vld_d[s] = vld_q[s-1];
          err_d[s] = err_q[s-1];
          dat_d[s] = dat_q[s-1];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
        err_q <= '0;
        dat_q <= '{default: '0};
      end else begin
        vld_q <= vld_d;
        err_q <= err_d;
        dat_q <= dat_d;
      end
    end

    assign req_rdy[p]                  = adv;
    assign rsp_vld[p]                  = vld_q[LATENCY-1];
    assign rsp_err[p]                  = err_q[LATENCY-1];
    assign rsp_data[p*DATA_W +: DATA_W] = dat_q[LATENCY-1];
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } st_t;

  st_t               st_q, st_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] sig_q, sig_d;
  logic              done_q, done_d;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    sig_d  = sig_q;
    done_d = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (scan_start) begin
          st_d  = S_SCAN;
          cnt_d = '0;
          acc_d = '0;
        end
      end
      S_SCAN: begin
        acc_d = acc_q + rom_word(cnt_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH-1)) st_d = S_DONE;
      end
      S_DONE: begin
        sig_d  = acc_q;
        done_d = 1'b1;
        st_d   = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      acc_q  <= '0;
      sig_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      sig_q  <= sig_d;
      done_q <= done_d;
    end
  end

  assign scan_busy = (st_q == S_SCAN);
  assign scan_done = done_q;
  assign scan_sig  = sig_q;

endmodule

// File: doc/romc_mp.md
ROMC_MP -- requirements
Module: romc_mp

Interface
REQ-001 Parameter DATA_W, default 64: ROM word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 8: number of ROM words; SHALL be 2..256.
REQ-003 Parameter ADDR_W, default 3: address width; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-004 Parameter NPORTS, default 2: number of independent read ports; SHALL be 1..8.
REQ-005 Parameter LATENCY, default 1: read pipeline depth in cycles; SHALL be 1 or 2.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 req_vld  input  NPORTS  per-port read request valid.
REQ-009 req_addr  input  NPORTS*ADDR_W  per-port address; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-010 req_rdy  output  NPORTS  per-port request accept.
REQ-011 rsp_vld  output  NPORTS  per-port response valid.
REQ-012 rsp_data  output  NPORTS*DATA_W  per-port read data; port p occupies bits [p*DATA_W +: DATA_W].
REQ-013 rsp_err  output  NPORTS  per-port out-of-range flag, qualified by rsp_vld.
REQ-014 rsp_rdy  input  NPORTS  per-port response accept.
REQ-015 scan_start  input  1  starts a signature scan of the whole ROM.
REQ-016 scan_busy  output  1  scan in progress.
REQ-017 scan_done  output  1  one-cycle pulse when scan_sig is updated.
REQ-018 scan_sig  output  DATA_W  modular sum of all ROM words from the last completed scan.

Function
REQ-019 ROM contents SHALL be fixed: word i = byte (8'h11*i mod 256) replicated across DATA_W/8 bytes.
REQ-020 Request accepted on port p when req_vld[p] && req_rdy[p]; response data/err SHALL appear with rsp_vld[p]=1 exactly LATENCY cycles after the accept edge when no stall occurs.
REQ-021 Each port SHALL have a LATENCY-stage pipeline of valid/addr/data; it advances when the final stage is empty or rsp_rdy[p]=1, otherwise all stages hold.
REQ-022 req_rdy[p] SHALL equal the port's advance condition (combinational from rsp_rdy[p] and final-stage valid); back-to-back accepts give one response per cycle.
REQ-023 While rsp_vld[p]=1 and rsp_rdy[p]=0, rsp_data[p], rsp_err[p] and rsp_vld[p] SHALL remain stable.
REQ-024 Address >= DEPTH SHALL return rsp_data=0, rsp_err=1; in-range addresses return rsp_err=0.
REQ-025 Ports SHALL be fully independent: simultaneous requests to the same or different addresses on all ports SHALL be served without arbitration or stall.
REQ-026 Scan FSM states: IDLE, SCAN, DONE.
REQ-027 IDLE: scan_start=1 -> SCAN, counter=0, accumulator=0; scan_busy=1 from the next cycle.
REQ-028 SCAN: each cycle accumulator += word[counter] (mod 2**DATA_W), counter++; after counter DEPTH-1 is added -> DONE.
REQ-029 DONE: scan_sig <= accumulator, scan_done=1 for exactly that cycle, scan_busy=0, -> IDLE; scan_done asserts DEPTH+1 cycles after the edge sampling scan_start.
REQ-030 scan_start while SCAN or DONE SHALL be ignored; scan_sig SHALL hold its value until the next DONE.
REQ-031 Scan activity SHALL NOT affect read-port latency, ready or data.

Reset
REQ-032 On rst=1, immediately and independent of clk: all pipeline valids=0, rsp_vld=0, rsp_data=0, rsp_err=0, FSM=IDLE, counter=0, accumulator=0, scan_busy=0, scan_done=0, scan_sig=0.
REQ-033 req_rdy SHALL read 1 on all ports while and after reset (pipelines empty).
REQ-034 Reset asserted mid-request or mid-scan SHALL discard in-flight responses and the partial sum; no rsp_vld or scan_done pulse follows deassertion without new stimulus.

Verification
REQ-035 Defaults, LATENCY=1, rsp_rdy=all 1: port0 addr 0..7 one per cycle, port1 addr 7..0 -> each response one cycle later; port0 first data 64'h0, port1 first data 64'h7777_7777_7777_7777, err=0.
REQ-036 Backpressure: port0 request addr 3, rsp_rdy[0]=0 for 4 cycles -> rsp_vld held with data 64'h3333_3333_3333_3333, req_rdy[0]=0 throughout, released on rsp_rdy[0]=1.
REQ-037 DEPTH=6, addr 6 and 7 -> rsp_data=0, rsp_err=1; addr 5 -> 64'h5555_5555_5555_5555, rsp_err=0.
REQ-038 Defaults, scan_start pulse -> scan_done one cycle, 9 cycles after start edge, scan_sig=64'hDDDD_DDDD_DDDD_DDDC; second scan_start during SCAN ignored.
REQ-039 LATENCY=2, continuous requests on both ports with random rsp_rdy -> in-order, lossless, duplicate-free responses matching REQ-019.
REQ-040 rst asserted mid-scan and with responses in flight -> outputs zero asynchronously; no rsp_vld or scan_done after release until new requests.
